// File: rtl/eth_rx_pkg.sv
// Shared types and constants for the receive-side Ethernet frame filter.
package eth_rx_pkg;

  typedef enum logic [1:0] {
    HDR,
    PAYLOAD,
    DROP
  } rx_state_t;

  localparam int          ETH_HDR_LEN   = 14;
  localparam logic [47:0] ETH_BCAST_MAC = 48'hFFFF_FFFF_FFFF;

  // Frame counters stick at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry valid/ready buffer with a registered upstream ready, so the
// upstream ready path never depends combinationally on downstream ready.
module axis_skid_buffer #(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  input  logic [WIDTH-1:0] s_data,
  output logic             s_ready,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  input  logic             m_ready
);

  logic [WIDTH-1:0] mem_reg [2];
  logic             wr_ptr_reg;
  logic             rd_ptr_reg;
  logic [1:0]       count_reg;
  logic [1:0]       count_next;
  logic             s_ready_reg;
  logic             push;
  logic             pop;

  assign push       = s_valid && s_ready_reg;
  assign pop        = (count_reg != 2'd0) && m_ready;
  assign count_next = count_reg + {1'b0, push} - {1'b0, pop};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) mem_reg[i] <= '0;
      wr_ptr_reg  <= 1'b0;
      rd_ptr_reg  <= 1'b0;
      count_reg   <= 2'd0;
      s_ready_reg <= 1'b0;
    end else begin
      if (push) begin
        mem_reg[wr_ptr_reg] <= s_data;
        wr_ptr_reg          <= ~wr_ptr_reg;
      end
      if (pop) rd_ptr_reg <= ~rd_ptr_reg;
      count_reg <= count_next;
      // Ready for the coming cycle is exact: at most one push can follow.
      s_ready_reg <= (count_next != 2'd2);
    end
  end

  assign s_ready = s_ready_reg;
  assign m_valid = (count_reg != 2'd0);
  assign m_data  = mem_reg[rd_ptr_reg];

endmodule

// File: rtl/eth_rx_frame_filter.sv
// Parses the Ethernet header, keeps frames for this station (or broadcast)
// with the configured EtherType, and streams their payload out.
module eth_rx_frame_filter
  import eth_rx_pkg::*;
#(
  parameter logic [47:0] LOCAL_MAC        = 48'h02_00_00_00_00_01,
  parameter logic [15:0] ETHERTYPE        = 16'h88B5,
  parameter bit          ACCEPT_BROADCAST = 1'b1
) (
  input  logic        i_clk,
  input  logic        rst,
  input  logic        i_eth_rx_valid,
  input  logic [7:0]  i_eth_rx_data,
  input  logic        i_eth_rx_last,
  output logic        o_eth_rx_ready,
  output logic        o_payload_valid,
  output logic [7:0]  o_payload_data,
  output logic        o_payload_last,
  input  logic        i_payload_ready,
  output logic        o_hdr_valid,
  output logic [47:0] o_src_mac,
  output logic [15:0] o_ethertype,
  output logic [15:0] o_frames_accepted,
  output logic [15:0] o_frames_dropped
);

  localparam logic [3:0] LAST_HDR_IDX = 4'(ETH_HDR_LEN - 1);

  rx_state_t                       state_reg;
  logic [3:0]                      byte_cnt_reg;
  logic [8*(ETH_HDR_LEN-1)-1:0]    hdr_shift_reg;
  logic [8*ETH_HDR_LEN-1:0]        hdr_full;
  logic                            live_reg;
  logic                            skid_ready;
  logic                            rx_beat;
  logic                            hdr_match;
  logic [47:0]                     dest_mac;
  logic [47:0]                     src_mac;
  logic [15:0]                     rx_type;
  logic [8:0]                      skid_out;

  // Outside PAYLOAD nothing is buffered, so ready only waits for reset release.
  assign o_eth_rx_ready = (state_reg == PAYLOAD) ? skid_ready : live_reg;
  assign rx_beat        = i_eth_rx_valid && o_eth_rx_ready;

  // Byte 13 is still on the bus when the header is judged.
  assign hdr_full  = {hdr_shift_reg, i_eth_rx_data};
  assign dest_mac  = hdr_full[111:64];
  assign src_mac   = hdr_full[63:16];
  assign rx_type   = hdr_full[15:0];
  assign hdr_match = ((dest_mac == LOCAL_MAC) ||
                      (ACCEPT_BROADCAST && (dest_mac == ETH_BCAST_MAC))) &&
                     (rx_type == ETHERTYPE);

  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) begin
      state_reg         <= HDR;
      byte_cnt_reg      <= 4'd0;
      hdr_shift_reg     <= '0;
      live_reg          <= 1'b0;
      o_hdr_valid       <= 1'b0;
      o_src_mac         <= 48'd0;
      o_ethertype       <= 16'd0;
      o_frames_accepted <= 16'd0;
      o_frames_dropped  <= 16'd0;
    end else begin
      live_reg    <= 1'b1;
      o_hdr_valid <= 1'b0;
      if (rx_beat) begin
        unique case (state_reg)
          HDR: begin
            hdr_shift_reg <= {hdr_shift_reg[8*(ETH_HDR_LEN-2)-1:0], i_eth_rx_data};
            if (i_eth_rx_last) begin
              byte_cnt_reg     <= 4'd0;
              o_frames_dropped <= sat_inc(o_frames_dropped);
            end else if (byte_cnt_reg == LAST_HDR_IDX) begin
              byte_cnt_reg <= 4'd0;
              if (hdr_match) begin
                state_reg         <= PAYLOAD;
                o_src_mac         <= src_mac;
                o_ethertype       <= rx_type;
                o_hdr_valid       <= 1'b1;
                o_frames_accepted <= sat_inc(o_frames_accepted);
              end else begin
                state_reg        <= DROP;
                o_frames_dropped <= sat_inc(o_frames_dropped);
              end
            end else begin
              byte_cnt_reg <= byte_cnt_reg + 4'd1;
            end
          end
          PAYLOAD: begin
            if (i_eth_rx_last) begin
              state_reg    <= HDR;
              byte_cnt_reg <= 4'd0;
            end
          end
          DROP: begin
            if (i_eth_rx_last) state_reg <= HDR;
          end
          default: state_reg <= HDR;
        endcase
      end
    end
  end

  axis_skid_buffer #(
    .WIDTH (9)
  ) u_payload_skid (
    .clk     (i_clk),
    .rst     (rst),
    .s_valid (i_eth_rx_valid && (state_reg == PAYLOAD)),
    .s_data  ({i_eth_rx_last, i_eth_rx_data}),
    .s_ready (skid_ready),
    .m_valid (o_payload_valid),
    .m_data  (skid_out),
    .m_ready (i_payload_ready)
  );

  assign o_payload_data = skid_out[7:0];
  assign o_payload_last = skid_out[8];

endmodule
